seg_display_scheduler: RTL and testbench
========================================

# seg_display_scheduler

Shares the 8-digit seven-segment display between three requesters: the error reporter (preemptive), timed result messages, and a live background status line. It sits between the central FSM/calculator and the segment scan driver. Each cycle it selects one registered 40-bit glyph-code word plus a per-digit blank mask for the driver. It owns all display timing: millisecond-scale ticks, result hold time and blink cadence.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 1000, scheduler tick rate; tick period = CLK_HZ/TICK_HZ cycles
- HOLD_TICKS, 2000, ticks a result message stays on display (≥1)
- BLINK_TICKS, 250, ticks per blink half-period (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- err_on  in  1  level; error display requested while high
- err_msg  in  40  error glyph codes, live (not latched)
- res_req  in  1  result request; held high until res_ack
- res_msg  in  40  result glyph codes; latched on ack
- res_blink  in  1  blink enable for this result; latched on ack
- stat_msg  in  40  background status glyph codes, live
- res_ack  out  1  one-cycle pulse: result accepted
- res_busy  out  1  high while a result is held (shown or paused)
- res_done  out  1  one-cycle pulse: result hold expired
- owner  out  2  0=STAT, 1=RES, 2=ERR
- disp_code  out  40  8×5-bit glyph codes; digit 7 = [39:35], digit 0 = [4:0]; code 31 = blank
- disp_blank  out  8  per-digit blank mask for the driver; 1 = digit off

## Operation
- Tick divider: free-running counter, 0..CLK_HZ/TICK_HZ−1. The tick strobe is high for one cycle at terminal count, then the counter wraps. The divider is never cleared except by reset.
- States: S_STAT, S_RES, S_ERR. A paused flag records that a result is suspended under an error. owner equals the state encoding.
- S_STAT:
  - err_on=1 → S_ERR.
  - Else res_req=1 → S_RES: latch res_msg and res_blink, clear hold_cnt and blink phase, pulse res_ack.
  - err_on has priority when it and res_req are sampled on the same edge; no ack is issued.
- S_RES:
  - err_on=1 → S_ERR with paused=1. hold_cnt and blink phase freeze.
  - Else on tick: if hold_cnt==HOLD_TICKS−1 → S_STAT and pulse res_done; otherwise hold_cnt+1.
- S_ERR:
  - err_on=0 and paused=1 → S_RES with paused=0, resuming the frozen hold_cnt and phase.
  - err_on=0 and paused=0 → S_STAT.
- Blink: a phase counter counts ticks in S_RES; phase toggles every BLINK_TICKS ticks and starts visible (0).
- disp_blank:
  - 8'hFF when S_RES, latched blink=1 and phase=1.
  - 8'h00 in every other case.
- disp_code by state: S_STAT → stat_msg, S_RES → latched result, S_ERR → err_msg.
- res_busy = (state==S_RES) | paused.
- res_req is ignored outside S_STAT. A request still high when a result completes is acked on the next edge after returning to S_STAT (back-to-back allowed).
- hold_cnt is wide enough for HOLD_TICKS−1; the blink counter is wide enough for BLINK_TICKS−1. No overflow is possible.

## Timing
- All outputs are registered.
- owner, disp_code and disp_blank update on the same edge as the state register. disp_code is computed from the next state and current inputs, so owner and disp_code never disagree.
- Live sources (stat_msg, err_msg) appear on disp_code one cycle after the input changes.
- res_req sampled high in S_STAT (err_on=0) at edge n → res_ack=1, owner=1, disp_code=res_msg all from edge n until edge n+1. res_ack is 0 again after edge n+1.
- Hold duration from ack to res_done: between (HOLD_TICKS−1)×P+1 and HOLD_TICKS×P cycles, where P = CLK_HZ/TICK_HZ. Time spent in S_ERR adds to this.
- res_done rises on the same edge owner returns to 0. res_busy falls on that edge.
- err_on rise → owner=2 on the next edge. err_on fall → owner returns on the next edge.
- Reset values (asynchronous, immediate):
  - state S_STAT, paused=0.
  - owner=0, res_ack=0, res_busy=0, res_done=0, disp_blank=8'h00.
  - disp_code = all digits 31.
  - All counters 0.
- Reset mid-result discards the latched message without a res_done pulse.

## Test plan
1. Reset then release with stat_msg=40'h0842108421 → after reset, disp_code is all 31 and owner=0. One cycle after release, disp_code=40'h0842108421. res_busy=0.
2. CLK_HZ=1000, TICK_HZ=100, HOLD_TICKS=3. res_req=1 with res_msg=M → res_ack pulses one cycle, owner=1, disp_code=M. res_done pulses 21–30 cycles after ack, on the same edge owner returns to 0.
3. HOLD_TICKS=8, BLINK_TICKS=1, res_blink=1 → disp_blank starts 00 and toggles 00/FF on every tick. Returns to 00 at res_done.
4. Mid-result (hold_cnt=1), err_on high for 50 cycles → owner=2, disp_code=err_msg, res_busy=1, hold frozen. After release, owner=1 with M. res_done arrives exactly 50 cycles later than in scenario 2.
5. err_on and res_req rise on the same cycle in S_STAT → owner=2, no res_ack. err_on falls → ack issued on the edge after owner returns to 0.
6. rst_n asserted while owner=1 → all outputs at reset values immediately. No res_done; res_busy=0 after release.

Source files
------------

// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scheduler
// Description : Arbitrates the 8-digit seven-segment display between three
//               sources: a preemptive error reporter, timed result messages
//               and a live background status line. Owns all display timing
//               (tick divider, result hold time, blink cadence) and presents
//               one registered glyph-code word plus blank mask per cycle.
// Ports       : clk, rst_n (async, active-low)
//               err_on/err_msg      - error request level and live glyphs
//               res_req/res_msg/res_blink/res_ack - result handshake
//               stat_msg            - live background status glyphs
//               res_busy/res_done   - result hold status / expiry pulse
//               owner               - 0=STAT 1=RES 2=ERR
//               disp_code/disp_blank- glyph word (digit 7 in [39:35]) and mask
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scheduler #(
   parameter int CLK_HZ      = 100_000_000,
   parameter int TICK_HZ     = 1000,
   parameter int HOLD_TICKS  = 2000,
   parameter int BLINK_TICKS = 250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        err_on,
   input  logic [39:0] err_msg,
   input  logic        res_req,
   input  logic [39:0] res_msg,
   input  logic        res_blink,
   input  logic [39:0] stat_msg,
   output logic        res_ack,
   output logic        res_busy,
   output logic        res_done,
   output logic [1:0]  owner,
   output logic [39:0] disp_code,
   output logic [7:0]  disp_blank
);

   localparam int DIV_CYCLES = CLK_HZ / TICK_HZ;
   localparam int DIV_W      = (DIV_CYCLES  > 1) ? $clog2(DIV_CYCLES)  : 1;
   localparam int HOLD_W     = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
   localparam int BLINK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
   localparam logic [39:0]        ALL_BLANK  = {8{5'd31}};

   typedef enum logic [1:0] {
      S_STAT = 2'd0,
      S_RES  = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 paused_q, paused_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic [BLINK_W-1:0]   bcnt_q, bcnt_d;
   logic                 phase_q, phase_d;
   logic [39:0]          msg_q, msg_d;
   logic                 blink_en_q, blink_en_d;
   logic                 ack_q, ack_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic [1:0]           owner_q, owner_d;
   logic [39:0]          code_q, code_d;
   logic [7:0]           blank_q, blank_d;
   logic                 tick;

   // Free-running divider; only reset ever clears it, so tick alignment is
   // independent of result/error activity.
   assign tick = (div_q == DIV_LAST);

   always_comb begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
   end

   always_comb begin
      state_d    = state_q;
      paused_d   = paused_q;
      hold_d     = hold_q;
      bcnt_d     = bcnt_q;
      phase_d    = phase_q;
      msg_d      = msg_q;
      blink_en_d = blink_en_q;
      ack_d      = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         S_STAT: begin
            if (err_on) begin
               state_d = S_ERR;
            end else if (res_req) begin
               state_d    = S_RES;
               msg_d      = res_msg;
               blink_en_d = res_blink;
               hold_d     = '0;
               bcnt_d     = '0;
               phase_d    = 1'b0;
               ack_d      = 1'b1;
            end
         end
         S_RES: begin
            // Error preempts before the tick is counted, so hold and blink
            // state freeze exactly where they were.
            if (err_on) begin
               state_d  = S_ERR;
               paused_d = 1'b1;
            end else if (tick) begin
               if (hold_q == HOLD_LAST) begin
                  state_d = S_STAT;
                  done_d  = 1'b1;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
               if (bcnt_q == BLINK_LAST) begin
                  bcnt_d  = '0;
                  phase_d = ~phase_q;
               end else begin
                  bcnt_d = bcnt_q + BLINK_W'(1);
               end
            end
         end
         S_ERR: begin
            if (!err_on) begin
               state_d  = paused_q ? S_RES : S_STAT;
               paused_d = 1'b0;
            end
         end
         default: begin
            state_d  = S_STAT;
            paused_d = 1'b0;
         end
      endcase
   end

   // Display outputs are derived from the next state so they change on the
   // same edge as owner and can never disagree with it.
   always_comb begin
      owner_d = state_d;
      busy_d  = (state_d == S_RES) | paused_d;
      blank_d = 8'h00;
      case (state_d)
         S_STAT:  code_d = stat_msg;
         S_RES:   code_d = msg_d;
         S_ERR:   code_d = err_msg;
         default: code_d = ALL_BLANK;
      endcase
      if ((state_d == S_RES) && blink_en_d && phase_d) begin
         blank_d = 8'hFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_STAT;
         paused_q   <= 1'b0;
         div_q      <= '0;
         hold_q     <= '0;
         bcnt_q     <= '0;
         phase_q    <= 1'b0;
         msg_q      <= '0;
         blink_en_q <= 1'b0;
         ack_q      <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         owner_q    <= 2'd0;
         code_q     <= ALL_BLANK;
         blank_q    <= 8'h00;
      end else begin
         state_q    <= state_d;
         paused_q   <= paused_d;
         div_q      <= div_d;
         hold_q     <= hold_d;
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         msg_q      <= msg_d;
         blink_en_q <= blink_en_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         owner_q    <= owner_d;
         code_q     <= code_d;
         blank_q    <= blank_d;
      end
   end

   assign res_ack    = ack_q;
   assign res_done   = done_q;
   assign res_busy   = busy_q;
   assign owner      = owner_q;
   assign disp_code  = code_q;
   assign disp_blank = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_scheduler
// Description : Self-checking bench for seg_display_scheduler. A behavioural
//               model tracks owner / result progress in plain tick counts and
//               every output is compared to it on each falling edge. Directed
//               scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scheduler;

   localparam int P_CLK   = 1000;
   localparam int P_TICK  = 100;
   localparam int P_HOLD  = 3;
   localparam int P_BLINK = 1;
   localparam int P       = P_CLK / P_TICK;
   localparam logic [39:0] ALL_BLANK = {8{5'd31}};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        err_on = 1'b0;
   logic [39:0] err_msg = '0;
   logic        res_req = 1'b0;
   logic [39:0] res_msg = '0;
   logic        res_blink = 1'b0;
   logic [39:0] stat_msg = '0;
   logic        res_ack, res_busy, res_done;
   logic [1:0]  owner;
   logic [39:0] disp_code;
   logic [7:0]  disp_blank;

   seg_display_scheduler #(
      .CLK_HZ(P_CLK), .TICK_HZ(P_TICK), .HOLD_TICKS(P_HOLD), .BLINK_TICKS(P_BLINK)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .err_on(err_on), .err_msg(err_msg),
      .res_req(res_req), .res_msg(res_msg), .res_blink(res_blink),
      .stat_msg(stat_msg),
      .res_ack(res_ack), .res_busy(res_busy), .res_done(res_done),
      .owner(owner), .disp_code(disp_code), .disp_blank(disp_blank)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // ---------------- behavioural model ----------------
   // m_mode: 0 status, 1 result shown, 2 error. m_ticks counts ticks the
   // current result has spent on display; k counts clock edges since reset.
   int          m_mode, m_ticks, k;
   bit          m_paused, m_blink;
   logic [39:0] m_msg;
   logic        e_ack, e_done, e_busy;
   logic [1:0]  e_owner;
   logic [39:0] e_code;
   logic [7:0]  e_blank;

   task automatic model_reset();
      m_mode = 0; m_ticks = 0; k = 0; m_paused = 0; m_blink = 0; m_msg = '0;
      e_ack = 0; e_done = 0; e_busy = 0; e_owner = 2'd0;
      e_code = ALL_BLANK; e_blank = 8'h00;
   endtask

   task automatic model_step();
      bit is_tick;
      is_tick = ((k % P) == P - 1);
      k++;
      e_ack = 0; e_done = 0;
      if (m_mode == 0) begin
         if (err_on) m_mode = 2;
         else if (res_req) begin
            m_mode = 1; m_msg = res_msg; m_blink = res_blink; m_ticks = 0; e_ack = 1;
         end
      end else if (m_mode == 1) begin
         if (err_on) begin
            m_mode = 2; m_paused = 1;
         end else if (is_tick) begin
            m_ticks++;
            if (m_ticks == P_HOLD) begin
               m_mode = 0; e_done = 1;
            end
         end
      end else begin
         if (!err_on) begin
            m_mode = m_paused ? 1 : 0;
            m_paused = 0;
         end
      end
      e_owner = 2'(m_mode);
      e_busy  = (m_mode == 1) || m_paused;
      e_code  = (m_mode == 0) ? stat_msg : (m_mode == 1) ? m_msg : err_msg;
      e_blank = (m_mode == 1 && m_blink && ((m_ticks / P_BLINK) % 2 == 1)) ? 8'hFF : 8'h00;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("owner",      40'(owner),      40'(e_owner));
      check("disp_code",  disp_code,       e_code);
      check("disp_blank", 40'(disp_blank), 40'(e_blank));
      check("res_ack",    40'(res_ack),    40'(e_ack));
      check("res_done",   40'(res_done),   40'(e_done));
      check("res_busy",   40'(res_busy),   40'(e_busy));
   end

   // One clock edge; the model consumes it with the inputs in effect there.
   task automatic cyc_step();
      @(posedge clk);
      if (rst_n) model_step();
      cyc++;
      #1;
   endtask

   function automatic logic [39:0] rnd40();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[39:0];
   endfunction

   task automatic align_tick();
      while ((k % P) != 0) cyc_step();
   endtask

   // Waits for res_done; returns cycles since t0 or -1 on timeout.
   task automatic wait_done(input int t0, input int budget, output int d);
      d = -1;
      for (int i = 0; i < budget; i++) begin
         cyc_step();
         if (res_done) begin
            d = cyc - t0;
            break;
         end
      end
      if (d < 0) check("done_timeout", 40'(0), 40'(1));
   endtask

   initial begin
      int t_ack, d;
      logic [39:0] m1, m2, m3, e2;
      model_reset();

      // Scenario 1: reset state and first status word
      repeat (3) cyc_step();
      check("rst_code",  disp_code, ALL_BLANK);
      check("rst_owner", 40'(owner), 40'(0));
      stat_msg = 40'h0842108421;
      rst_n = 1'b1;
      cyc_step();
      check("stat_first", disp_code, 40'h0842108421);
      check("stat_busy",  40'(res_busy), 40'(0));
      repeat (4) cyc_step();

      // Scenario 2/3: result with blink, ack on an edge aligned to k%P==0 so
      // ticks land at offsets 9, 19, 29 after the ack.
      m1 = 40'h123456789A;
      align_tick();
      res_req = 1; res_msg = m1; res_blink = 1;
      cyc_step();
      t_ack = cyc;
      check("ack_pulse", 40'(res_ack), 40'(1));
      check("ack_owner", 40'(owner), 40'(1));
      check("ack_code",  disp_code, m1);
      check("ack_blank", 40'(disp_blank), 40'(8'h00));
      res_req = 0;
      cyc_step();
      check("ack_low", 40'(res_ack), 40'(0));
      d = -1;
      for (int i = 0; i < 40; i++) begin
         cyc_step();
         if (cyc - t_ack == 9)  check("blink_on",  40'(disp_blank), 40'(8'hFF));
         if (cyc - t_ack == 19) check("blink_off", 40'(disp_blank), 40'(8'h00));
         if (res_done) begin d = cyc - t_ack; break; end
      end
      check("hold_len",   40'(d), 40'(29));
      check("done_owner", 40'(owner), 40'(0));
      check("done_busy",  40'(res_busy), 40'(0));
      check("done_blank", 40'(disp_blank), 40'(8'h00));

      // Scenario 4: same alignment, 50-cycle error mid-result
      m2 = 40'hABCDE01234; e2 = 40'h0F0F0F0F0F;
      align_tick();
      res_req = 1; res_msg = m2; res_blink = 0;
      cyc_step();
      t_ack = cyc;
      res_req = 0;
      while (cyc - t_ack < 12) cyc_step();
      err_on = 1; err_msg = e2;
      cyc_step();
      check("err_owner", 40'(owner), 40'(2));
      check("err_code",  disp_code, e2);
      check("err_busy",  40'(res_busy), 40'(1));
      repeat (49) cyc_step();
      err_on = 0;
      cyc_step();
      check("resume_owner", 40'(owner), 40'(1));
      check("resume_code",  disp_code, m2);
      wait_done(t_ack, 60, d);
      check("hold_len_err", 40'(d), 40'(79));

      // Scenario 5: err_on and res_req together in status state
      m3 = 40'h5555500000;
      repeat (3) cyc_step();
      err_on = 1; res_req = 1; res_msg = m3;
      cyc_step();
      check("sim_owner", 40'(owner), 40'(2));
      check("sim_noack", 40'(res_ack), 40'(0));
      repeat (4) cyc_step();
      err_on = 0;
      cyc_step();
      check("sim_back_owner", 40'(owner), 40'(0));
      check("sim_back_noack", 40'(res_ack), 40'(0));
      cyc_step();
      check("sim_ack",  40'(res_ack), 40'(1));
      check("sim_code", disp_code, m3);
      t_ack = cyc;
      res_req = 0;
      wait_done(t_ack, 40, d);

      // Scenario 6: reset while a result is shown
      res_req = 1; res_msg = 40'h1111122222;
      cyc_step();
      res_req = 0;
      repeat (5) cyc_step();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_owner", 40'(owner), 40'(0));
      check("mid_rst_busy",  40'(res_busy), 40'(0));
      check("mid_rst_code",  disp_code, ALL_BLANK);
      check("mid_rst_blank", 40'(disp_blank), 40'(0));
      check("mid_rst_done",  40'(res_done), 40'(0));
      repeat (2) cyc_step();
      rst_n = 1'b1;
      cyc_step();
      check("post_rst_busy", 40'(res_busy), 40'(0));
      begin
         int done_seen = 0;
         repeat (40) begin
            cyc_step();
            if (res_done) done_seen++;
         end
         check("post_rst_no_done", 40'(done_seen), 40'(0));
      end

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) stat_msg = rnd40();
         if ($urandom_range(0, 3) == 0) err_msg = rnd40();
         if (err_on) begin
            if ($urandom_range(0, 19) == 0) err_on = 0;
         end else if ($urandom_range(0, 59) == 0) begin
            err_on = 1;
         end
         if (res_req && e_ack) begin
            res_req = ($urandom_range(0, 3) == 0);
            res_msg = rnd40(); res_blink = 1'($urandom_range(0, 1));
         end else if (!res_req && $urandom_range(0, 7) == 0) begin
            res_req = 1; res_msg = rnd40(); res_blink = 1'($urandom_range(0, 1));
         end
         cyc_step();
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
